ps2_key_mapper: RTL and testbench
=================================

// Module: ps2_key_mapper
// PURPOSE
//  Producer side of the KEY_PRESSED interface consumed by the direction latch.
//  Turns PS/2 set-2 scan-code bytes (from the PS/2 byte receiver) into per-key held state.
//  Presents held keys on KEY_PRESSED as 5-bit codes, code = 4*player + dir
//  (dir 0 up, 1 down, 2 left, 3 right), so all four players are serviced by a round-robin sweep.
// PARAMETERS
//  TIMEOUT_CYCLES  200000  max CLOCK_50 cycles allowed between a prefix byte (E0/F0) and the next byte
//  IDLE_CODE       5'd31   KEY_PRESSED value when nothing is presented; must lie outside 0..16
// PORTS
//  CLOCK_50     in   1   system clock; all state on posedge
//  resetn       in   1   asynchronous, active-low reset
//  scan_code    in   8   scan-code byte from the PS/2 receiver
//  scan_valid   in   1   one-cycle strobe; scan_code is valid in the same cycle
//  KEY_PRESSED  out  5   key code for the direction latch; IDLE_CODE when none
//  key_held     out  16  bit k set while the key with code k is held
//  seq_timeout  out  1   one-cycle pulse when an incomplete prefix sequence is abandoned
//  start_pulse  out  1   one-cycle pulse on a space make (KEYMAP_START_KEY_EN only)
// BEHAVIOUR
//  Reset: KEY_PRESSED=IDLE_CODE, key_held=0, seq_timeout=0, start_pulse=0, FSM=IDLE,
//   sweep ptr=0, timeout count=0. Reset asserted mid-sequence discards the sequence.
//  Key map, make codes:
//   P1: W 1D, S 1B, A 1C, D 23 -> codes 0-3
//   P2: E0 75, E0 72, E0 6B, E0 74 -> codes 4-7
//   P3: I 43, K 42, J 3B, L 4B -> codes 8-11
//   P4: keypad 75, 73, 6B, 74 (no E0) -> codes 12-15
//  FSM, advanced only when scan_valid=1:
//   IDLE:    E0 -> EXT; F0 -> BRK; other byte -> make lookup, stay IDLE
//   EXT:     F0 -> EXT_BRK; E0 -> EXT; other byte -> extended make lookup, go IDLE
//   BRK:     E0 or F0 -> IDLE and drop the byte; other byte -> break lookup, go IDLE
//   EXT_BRK: E0 or F0 -> IDLE and drop the byte; other byte -> extended break lookup, go IDLE
//  Unmapped or wrong-table bytes (FA, AA, E1, ...) are ignored; the FSM still returns to IDLE.
//  Make hit at cycle t:
//   - key_held[k] is set at t+1.
//   - KEY_PRESSED=k at t+1 for one cycle, overriding the sweep.
//   - A repeat make (typematic) of a held key behaves the same way.
//  Break hit at cycle t: key_held[k] is cleared at t+1. A break for a key not held has no effect.
//  Sweep:
//   - A 4-bit ptr increments every cycle and wraps 15->0.
//   - When no make override is active: KEY_PRESSED <= key_held[ptr] ? ptr : IDLE_CODE.
//   - Every held key is therefore presented at least once every 16 cycles.
//   - Two held keys of the same player: the one visited later in the sweep wins; this is accepted.
//  Timeout:
//   - The counter clears on every scan_valid and counts only in EXT, BRK and EXT_BRK.
//   - When it reaches TIMEOUT_CYCLES-1: FSM -> IDLE and seq_timeout pulses for 1 cycle.
//   - A scan_valid arriving in that same cycle wins: the byte is processed and no timeout is flagged.
//  The counter saturates, so no wrap occurs. key_held is never altered by a timeout.
// CONFIGURATION
//  KEYMAP_START_KEY_EN defined:
//   - Space make (29, no E0) -> KEY_PRESSED=5'd16 for one cycle and start_pulse for one cycle.
//   - Space is not tracked in key_held.
//  KEYMAP_START_KEY_EN undefined: 29 is unmapped; start_pulse is tied to 0.
// STRUCTURE
//  Package turf_pkg holds:
//   - dir codes DIR_UP/DOWN/LEFT/RIGHT
//   - IDLE_CODE and START_CODE=16
//   - scan constants SC_EXT=E0, SC_BRK=F0, SC_SPACE=29
//   - FSM state enum
//  Sub-module keymap_lut: combinational; inputs (scan_code, ext); outputs (hit, code[3:0]).
//  The FSM, held register, sweep and timeout stay in ps2_key_mapper.
// TESTING
//  1. Bytes 1D -> KEY_PRESSED=0 the next cycle and key_held=0x0001.
//     Then F0 1D -> key_held=0 and the sweep outputs only 31.
//  2. E0 75 -> key_held[4]=1. Keypad 75 -> key_held[12]=1.
//     Then E0 F0 75 -> only bit 12 remains set.
//  3. Hold 1D, 42 and 74 -> within any 16-cycle window KEY_PRESSED shows 0, 9 and 15; elsewhere 31.
//  4. E0 followed by silence for TIMEOUT_CYCLES -> seq_timeout pulses once.
//     Then 72 -> treated as a non-extended byte: unmapped, no change.
//  5. Assert resetn low between F0 and 1D while 1D is held -> key_held=0.
//     The later 1D is a make: key_held=0x0001.
//  6. With KEYMAP_START_KEY_EN, byte 29 -> KEY_PRESSED=16 and start_pulse=1 for one cycle, key_held unchanged.
//     Without the macro -> no response.

Source files
------------

// File: rtl/turf_pkg.sv
// Shared constants for the PS/2 key mapper: direction codes,
// special KEY_PRESSED values, scan-code prefixes and FSM states.
package turf_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [4:0] IDLE_CODE  = 5'd31;
  localparam logic [4:0] START_CODE = 5'd16;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kb_state_e;

  function automatic logic [3:0] key_code(
    input logic [1:0] player,
    input logic [1:0] dir
  );
    return {player, dir};
  endfunction

endpackage

// File: rtl/keymap_lut.sv
// Scan-code to key-code table (combinational).
// Ports: scan_code, ext (E0 seen) in; hit, code[3:0] out.
module keymap_lut
  import turf_pkg::*;
(
  input  logic [7:0] scan_code,
  input  logic       ext,
  output logic       hit,
  output logic [3:0] code
);

  always_comb begin
    hit  = 1'b1;
    code = '0;
    unique case ({ext, scan_code})
      9'h01D:  code = key_code(2'd0, DIR_UP);
      9'h01B:  code = key_code(2'd0, DIR_DOWN);
      9'h01C:  code = key_code(2'd0, DIR_LEFT);
      9'h023:  code = key_code(2'd0, DIR_RIGHT);
      9'h175:  code = key_code(2'd1, DIR_UP);
      9'h172:  code = key_code(2'd1, DIR_DOWN);
      9'h16B:  code = key_code(2'd1, DIR_LEFT);
      9'h174:  code = key_code(2'd1, DIR_RIGHT);
      9'h043:  code = key_code(2'd2, DIR_UP);
      9'h042:  code = key_code(2'd2, DIR_DOWN);
      9'h03B:  code = key_code(2'd2, DIR_LEFT);
      9'h04B:  code = key_code(2'd2, DIR_RIGHT);
      9'h075:  code = key_code(2'd3, DIR_UP);
      9'h073:  code = key_code(2'd3, DIR_DOWN);
      9'h06B:  code = key_code(2'd3, DIR_LEFT);
      9'h074:  code = key_code(2'd3, DIR_RIGHT);
      default: hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_mapper.sv
// PS/2 set-2 bytes -> held-key bitmap and round-robin KEY_PRESSED.
// Ports: CLOCK_50, resetn, scan_code, scan_valid in;
// KEY_PRESSED, key_held, seq_timeout, start_pulse out.
// Option: KEYMAP_START_KEY_EN enables the space/start pulse.
module ps2_key_mapper #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter logic [4:0]  IDLE_CODE      = turf_pkg::IDLE_CODE
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  scan_code,
  input  logic        scan_valid,
  output logic [4:0]  KEY_PRESSED,
  output logic [15:0] key_held,
  output logic        seq_timeout,
  output logic        start_pulse
);

  import turf_pkg::*;

  localparam int CW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  kb_state_e     state;
  logic [3:0]    ptr;
  logic [CW-1:0] cnt;
  logic          ext;
  logic          hit;
  logic [3:0]    code;
  logic          is_pfx;
  logic          is_space;
  logic          sp_q;

  assign ext    = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign is_pfx = (scan_code == SC_EXT) || (scan_code == SC_BRK);

`ifdef KEYMAP_START_KEY_EN
  assign is_space = (scan_code == SC_SPACE);
  assign start_pulse = sp_q;
`else
  assign is_space = 1'b0;
  assign start_pulse = 1'b0;
`endif

  keymap_lut u_lut (
    .scan_code (scan_code),
    .ext       (ext),
    .hit       (hit),
    .code      (code)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      KEY_PRESSED <= IDLE_CODE;
      key_held    <= '0;
      seq_timeout <= 1'b0;
      sp_q        <= 1'b0;
    end else begin
      seq_timeout <= 1'b0;
      sp_q        <= 1'b0;
      ptr         <= ptr + 4'd1;
      KEY_PRESSED <= key_held[ptr] ? {1'b0, ptr} : IDLE_CODE;
      if (scan_valid) begin
        cnt <= '0;
        unique case (state)
          ST_IDLE: begin
            unique case (1'b1)
              scan_code == SC_EXT: state <= ST_EXT;
              scan_code == SC_BRK: state <= ST_BRK;
              default: begin
                if (hit) begin
                  key_held[code] <= 1'b1;
                  KEY_PRESSED    <= {1'b0, code};
                end else if (is_space) begin
                  KEY_PRESSED <= START_CODE;
                  sp_q        <= 1'b1;
                end
              end
            endcase
          end
          ST_EXT: begin
            unique case (1'b1)
              scan_code == SC_BRK: state <= ST_EXT_BRK;
              scan_code == SC_EXT: state <= ST_EXT;
              default: begin
                state <= ST_IDLE;
                if (hit) begin
                  key_held[code] <= 1'b1;
                  KEY_PRESSED    <= {1'b0, code};
                end
              end
            endcase
          end
          default: begin
            // BRK / EXT_BRK: a stray prefix aborts the sequence
            state <= ST_IDLE;
            if (!is_pfx && hit)
              key_held[code] <= 1'b0;
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (cnt == TO_LAST) begin
          state       <= ST_IDLE;
          seq_timeout <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Directed bench for ps2_key_mapper with a short timeout.
// Expected values are hand-derived from the key map.
module tb_ps2_key_mapper;

  localparam int T = 50;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic [4:0]  KEY_PRESSED;
  logic [15:0] key_held;
  logic        seq_timeout;
  logic        start_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  ps2_key_mapper #(
    .TIMEOUT_CYCLES (T),
    .IDLE_CODE      (5'd31)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .KEY_PRESSED (KEY_PRESSED),
    .key_held    (key_held),
    .seq_timeout (seq_timeout),
    .start_pulse (start_pulse)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
  endtask

  int bad;
  int idle_n;
  int at;
  int pulses;
  logic s0, s9, s15;

  initial begin
    resetn     = 1'b0;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    repeat (3) tick();
    chk("rst_kp", KEY_PRESSED, 31);
    chk("rst_held", key_held, 0);
    chk("rst_to", seq_timeout, 0);
    chk("rst_start", start_pulse, 0);
    resetn = 1'b1;
    tick();

    // make/break of W
    send(8'h1D);
    chk("w_kp", KEY_PRESSED, 0);
    chk("w_held", key_held, 16'h0001);
    send(8'hF0);
    send(8'h1D);
    chk("w_brk", key_held, 0);
    tick();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (KEY_PRESSED != 5'd31) bad++;
    end
    chk("sweep_idle", bad, 0);

    // extended vs keypad 75
    send(8'hE0);
    send(8'h75);
    chk("e75_kp", KEY_PRESSED, 4);
    chk("e75_held", key_held, 16'h0010);
    send(8'h75);
    chk("kp75_kp", KEY_PRESSED, 12);
    chk("kp75_held", key_held, 16'h1010);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("e75_brk", key_held, 16'h1000);
    send(8'hF0);
    send(8'h75);
    chk("kp75_brk", key_held, 0);

    // three held keys in the sweep
    send(8'h1D);
    send(8'h42);
    chk("k_kp", KEY_PRESSED, 9);
    send(8'h74);
    chk("three_held", key_held, 16'h8201);
    send(8'hF0);
    send(8'h1B);
    chk("brk_unheld", key_held, 16'h8201);
    send(8'hFA);
    chk("unmapped", key_held, 16'h8201);
    tick();
    s0 = 0; s9 = 0; s15 = 0; idle_n = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (KEY_PRESSED == 5'd0)  s0  = 1;
      if (KEY_PRESSED == 5'd9)  s9  = 1;
      if (KEY_PRESSED == 5'd15) s15 = 1;
      if (KEY_PRESSED == 5'd31) idle_n++;
    end
    chk("sweep_0", s0, 1);
    chk("sweep_9", s9, 1);
    chk("sweep_15", s15, 1);
    chk("sweep_idle_n", idle_n, 13);
    send(8'hF0); send(8'h1D);
    send(8'hF0); send(8'h42);
    send(8'hF0); send(8'h74);
    chk("clr_all", key_held, 0);

    // timeout after E0
    send(8'hE0);
    at = -1;
    pulses = 0;
    for (int i = 1; i <= T + 10; i++) begin
      tick();
      if (seq_timeout) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    chk("to_pulses", pulses, 1);
    chk("to_time", at, T);
    send(8'h72);
    chk("to_72_held", key_held, 0);
    chk("to_72_kp", KEY_PRESSED, 31);

    // byte in the last cycle beats the timeout
    send(8'hE0);
    repeat (T - 1) tick();
    send(8'h75);
    chk("edge_to", seq_timeout, 0);
    chk("edge_held", key_held, 16'h0010);
    pulses = 0;
    for (int i = 0; i < T + 5; i++) begin
      tick();
      if (seq_timeout) pulses++;
    end
    chk("edge_nopulse", pulses, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("edge_clr", key_held, 0);

    // reset in the middle of a break sequence
    send(8'h1D);
    send(8'hF0);
    resetn = 1'b0;
    #1;
    chk("mid_rst", key_held, 0);
    tick();
    resetn = 1'b1;
    tick();
    send(8'h1D);
    chk("post_rst", key_held, 16'h0001);

    // space / start key
    send(8'h29);
`ifdef KEYMAP_START_KEY_EN
    chk("sp_kp", KEY_PRESSED, 16);
    chk("sp_pulse", start_pulse, 1);
    chk("sp_held", key_held, 16'h0001);
    tick();
    chk("sp_pulse_off", start_pulse, 0);
`else
    chk("sp_kp", KEY_PRESSED == 5'd16, 0);
    chk("sp_pulse", start_pulse, 0);
    chk("sp_held", key_held, 16'h0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
